// File: rtl/key_conditioner.sv
// key_conditioner
// Debounces the two board push-buttons and turns them into clean, registered
// single-cycle events for the calendar core, with auto-repeat while a key is
// held past the long-press time.
//
// Ports:
//   clk_in      in   1  system clock (only clock)
//   rst         in   1  synchronous, active-high reset
//   key         in   2  raw asynchronous key pins
//   key_level   out  2  debounced pressed state (1 = pressed)
//   key_press   out  2  one-cycle pulse on accepted press and on each auto-repeat
//   key_release out  2  one-cycle pulse on accepted release
//   key_long    out  2  high from the long-press event until release is accepted
module key_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
   parameter int unsigned LONG_CYCLES     = 100_000_000,
   parameter int unsigned REPEAT_CYCLES   = 25_000_000,
   parameter bit          REPEAT_EN       = 1'b1,
   parameter logic        PRESS_LEVEL     = 1'b0
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic [1:0] key,
   output logic [1:0] key_level,
   output logic [1:0] key_press,
   output logic [1:0] key_release,
   output logic [1:0] key_long
);

   localparam logic [31:0] DEB_LAST  = DEBOUNCE_CYCLES - 1;
   localparam logic [31:0] LONG_LAST = LONG_CYCLES - 1;
   localparam logic [31:0] REP_LAST  = REPEAT_CYCLES - 1;

   typedef enum logic [2:0] {
      RELEASED,
      PRESS_WAIT,
      HELD,
      REPEAT,
      RELEASE_WAIT
   } state_t;

   for (genvar i = 0; i < 2; i++) begin : g_ch
      logic        sync1;
      logic        sync2;
      logic        k_s;
      state_t      state;
      logic [31:0] cnt;
      logic        level;
      logic        press;
      logic        rel;
      logic        long_q;

      // Two-flop synchronizer; reset parks it at the idle pin level so a key
      // held through reset is seen as a fresh press afterwards.
      always_ff @(posedge clk_in) begin
         if (rst) begin
            sync1 <= ~PRESS_LEVEL;
            sync2 <= ~PRESS_LEVEL;
         end else begin
            sync1 <= key[i];
            sync2 <= sync1;
         end
      end

      assign k_s = (sync2 == PRESS_LEVEL);

      // Per-key channel FSM. The counter is cleared on every state change so
      // each wait always starts from zero.
      always_ff @(posedge clk_in) begin
         if (rst) begin
            state  <= RELEASED;
            cnt    <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
            rel    <= 1'b0;
            long_q <= 1'b0;
         end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            case (state)
               RELEASED: begin
                  if (k_s) begin
                     state <= PRESS_WAIT;
                     cnt   <= '0;
                  end
               end
               PRESS_WAIT: begin
                  if (!k_s) begin
                     state <= RELEASED;
                     cnt   <= '0;
                  end else if (cnt == DEB_LAST) begin
                     state <= HELD;
                     cnt   <= '0;
                     level <= 1'b1;
                     press <= 1'b1;
                  end else begin
                     cnt <= cnt + 32'd1;
                  end
               end
               HELD: begin
                  if (!k_s) begin
                     state <= RELEASE_WAIT;
                     cnt   <= '0;
                  end else if (cnt == LONG_LAST) begin
                     state  <= REPEAT;
                     cnt    <= '0;
                     long_q <= 1'b1;
                     press  <= REPEAT_EN;
                  end else begin
                     cnt <= cnt + 32'd1;
                  end
               end
               REPEAT: begin
                  if (!k_s) begin
                     state <= RELEASE_WAIT;
                     cnt   <= '0;
                  end else if (cnt == REP_LAST) begin
                     cnt   <= '0;
                     press <= REPEAT_EN;
                  end else begin
                     cnt <= cnt + 32'd1;
                  end
               end
               RELEASE_WAIT: begin
                  // A press returning before the release debounces restarts
                  // the long-press timer rather than resuming auto-repeat.
                  if (k_s) begin
                     state  <= HELD;
                     cnt    <= '0;
                     long_q <= 1'b0;
                  end else if (cnt == DEB_LAST) begin
                     state  <= RELEASED;
                     cnt    <= '0;
                     level  <= 1'b0;
                     long_q <= 1'b0;
                     rel    <= 1'b1;
                  end else begin
                     cnt <= cnt + 32'd1;
                  end
               end
               default: begin
                  state <= RELEASED;
                  cnt   <= '0;
               end
            endcase
         end
      end

      assign key_level[i]   = level;
      assign key_press[i]   = press;
      assign key_release[i] = rel;
      assign key_long[i]    = long_q;
   end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner
// Drives two key_conditioner instances (auto-repeat on and off) from the same
// key pins and compares them against a run-length reference model, plus
// directed cycle-exact expectations for the main scenarios.
module tb_key_conditioner;

   localparam int D = 4;
   localparam int L = 20;
   localparam int R = 6;

   logic       clk_in = 1'b0;
   logic       rst;
   logic [1:0] key;
   logic [1:0] lv0, pr0, rl0, lg0;
   logic [1:0] lv1, pr1, rl1, lg1;

   always #5 clk_in = ~clk_in;

   key_conditioner #(
      .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R),
      .REPEAT_EN(1'b1), .PRESS_LEVEL(1'b0)
   ) u_rep (
      .clk_in(clk_in), .rst(rst), .key(key),
      .key_level(lv0), .key_press(pr0), .key_release(rl0), .key_long(lg0)
   );

   key_conditioner #(
      .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R),
      .REPEAT_EN(1'b0), .PRESS_LEVEL(1'b0)
   ) u_norep (
      .clk_in(clk_in), .rst(rst), .key(key),
      .key_level(lv1), .key_press(pr1), .key_release(rl1), .key_long(lg1)
   );

   logic [1:0] o_lv[2], o_pr[2], o_rl[2], o_lg[2];
   assign o_lv[0] = lv0; assign o_lv[1] = lv1;
   assign o_pr[0] = pr0; assign o_pr[1] = pr1;
   assign o_rl[0] = rl0; assign o_rl[1] = rl1;
   assign o_lg[0] = lg0; assign o_lg[1] = lg1;

   // Reference model: index [d] = instance (0 repeat on, 1 repeat off), [c] = key.
   // m_on / m_off count consecutive synchronized pressed / released samples,
   // m_h counts held samples since acceptance or since a press came back.
   int         m_on[2][2], m_off[2][2], m_h[2][2];
   logic [1:0] m_s1[2], m_s2[2];
   logic [1:0] m_lv[2], m_pr[2], m_rl[2], m_lg[2];

   int checks = 0;
   int errors = 0;

   task automatic step(input logic [1:0] k, input logic r);
      logic ks;
      key = k;
      rst = r;
      @(posedge clk_in);
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 2; c++) begin
            m_pr[d][c] = 1'b0;
            m_rl[d][c] = 1'b0;
            if (r) begin
               m_s1[d][c] = 1'b0; m_s2[d][c] = 1'b0;
               m_on[d][c] = 0; m_off[d][c] = 0; m_h[d][c] = 0;
               m_lv[d][c] = 1'b0; m_lg[d][c] = 1'b0;
            end else begin
               ks = m_s2[d][c];
               m_s2[d][c] = m_s1[d][c];
               m_s1[d][c] = (k[c] == 1'b0);
               if (!m_lv[d][c]) begin
                  m_on[d][c] = ks ? m_on[d][c] + 1 : 0;
                  if (m_on[d][c] == D + 1) begin
                     m_lv[d][c] = 1'b1; m_pr[d][c] = 1'b1;
                     m_h[d][c] = 0; m_on[d][c] = 0; m_off[d][c] = 0;
                  end
               end else if (ks) begin
                  if (m_off[d][c] > 0) begin
                     m_off[d][c] = 0; m_h[d][c] = 0; m_lg[d][c] = 1'b0;
                  end else begin
                     m_h[d][c] = m_h[d][c] + 1;
                     if (m_h[d][c] == L) begin
                        m_lg[d][c] = 1'b1;
                        m_pr[d][c] = (d == 0);
                     end else if (m_h[d][c] > L && (m_h[d][c] - L) % R == 0) begin
                        m_pr[d][c] = (d == 0);
                     end
                  end
               end else begin
                  m_off[d][c] = m_off[d][c] + 1;
                  if (m_off[d][c] == D + 1) begin
                     m_lv[d][c] = 1'b0; m_lg[d][c] = 1'b0; m_rl[d][c] = 1'b1;
                     m_off[d][c] = 0; m_on[d][c] = 0;
                  end
               end
            end
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(2'b11, 1'b0);
   endtask

   task automatic test_reset;
      repeat (3) step(2'b11, 1'b1);
      checks++;
      if ({lv0, pr0, rl0, lg0, lv1, pr1, rl1, lg1} !== 16'h0000)
         begin errors++; $display("FAIL reset_outputs got %h exp 0000", {lv0, pr0, rl0, lg0, lv1, pr1, rl1, lg1}); end
      repeat (4) begin
         step(2'b11, 1'b0);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({o_lv[d], o_pr[d], o_rl[d], o_lg[d]} !== {m_lv[d], m_pr[d], m_rl[d], m_lg[d]}) begin
               errors++;
               $display("FAIL model_reset inst%0d got lv=%b pr=%b rl=%b lg=%b exp lv=%b pr=%b rl=%b lg=%b",
                        d, o_lv[d], o_pr[d], o_rl[d], o_lg[d], m_lv[d], m_pr[d], m_rl[d], m_lg[d]);
            end
         end
      end
   endtask

   task automatic test_clean_press;
      for (int e = 1; e <= 12; e++) begin
         step(2'b10, 1'b0);
         checks++;
         if (pr0 !== ((e == 7) ? 2'b01 : 2'b00) || lv0 !== ((e >= 7) ? 2'b01 : 2'b00) ||
             rl0 !== 2'b00 || lg0 !== 2'b00) begin
            errors++;
            $display("FAIL clean_press edge %0d got pr=%b lv=%b rl=%b lg=%b exp pr=%b lv=%b rl=00 lg=00",
                     e, pr0, lv0, rl0, lg0, (e == 7) ? 2'b01 : 2'b00, (e >= 7) ? 2'b01 : 2'b00);
         end
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({o_lv[d], o_pr[d], o_rl[d], o_lg[d]} !== {m_lv[d], m_pr[d], m_rl[d], m_lg[d]}) begin
               errors++;
               $display("FAIL model_clean inst%0d edge %0d got %b%b%b%b exp %b%b%b%b", d, e,
                        o_lv[d], o_pr[d], o_rl[d], o_lg[d], m_lv[d], m_pr[d], m_rl[d], m_lg[d]);
            end
         end
      end
      idle(15);
   endtask

   task automatic test_bounce;
      logic [1:0] k;
      int n;
      // Fixed 2-cycle chatter, then random low runs no longer than the debounce time.
      for (int i = 0; i < 30; i++) begin
         k = (i < 20 && (i / 2) % 2 == 0) ? 2'b10 : 2'b11;
         step(k, 1'b0);
         checks++;
         if ({lv0, pr0, rl0, lg0} !== 8'h00) begin
            errors++; $display("FAIL bounce_fixed cycle %0d got %h exp 00", i, {lv0, pr0, rl0, lg0});
         end
      end
      repeat (8) begin
         n = $urandom_range(D, 1);
         for (int i = 0; i < n + 6; i++) begin
            k = (i < n) ? 2'b10 : 2'b11;
            step(k, 1'b0);
            checks++;
            if ({lv0, pr0, rl0, lg0} !== 8'h00) begin
               errors++; $display("FAIL bounce_random run %0d got %h exp 00", n, {lv0, pr0, rl0, lg0});
            end
            for (int d = 0; d < 2; d++) begin
               checks++;
               if ({o_lv[d], o_pr[d], o_rl[d], o_lg[d]} !== {m_lv[d], m_pr[d], m_rl[d], m_lg[d]}) begin
                  errors++;
                  $display("FAIL model_bounce inst%0d got %b%b%b%b exp %b%b%b%b", d,
                           o_lv[d], o_pr[d], o_rl[d], o_lg[d], m_lv[d], m_pr[d], m_rl[d], m_lg[d]);
               end
            end
         end
      end
      for (int e = 1; e <= 10; e++) begin
         step(2'b10, 1'b0);
         checks++;
         if (pr0 !== ((e == 7) ? 2'b01 : 2'b00)) begin
            errors++; $display("FAIL bounce_accept edge %0d got %b exp %b", e, pr0, (e == 7) ? 2'b01 : 2'b00);
         end
      end
      idle(15);
   endtask

   task automatic test_long_hold;
      logic p;
      for (int e = 1; e <= 80; e++) begin
         step((e <= 65) ? 2'b01 : 2'b11, 1'b0);
         p = (e == 7) || (e >= 27 && e <= 63 && (e - 27) % 6 == 0);
         checks++;
         if (pr0 !== {p, 1'b0} || lg0 !== {(e >= 27 && e < 72), 1'b0} ||
             lv0 !== {(e >= 7 && e < 72), 1'b0} || rl0 !== {(e == 72), 1'b0}) begin
            errors++;
            $display("FAIL long_hold edge %0d got pr=%b lg=%b lv=%b rl=%b exp pr=%b lg=%b lv=%b rl=%b", e,
                     pr0, lg0, lv0, rl0, {p, 1'b0}, {(e >= 27 && e < 72), 1'b0},
                     {(e >= 7 && e < 72), 1'b0}, {(e == 72), 1'b0});
         end
         checks++;
         if (pr1 !== {(e == 7), 1'b0} || lg1 !== {(e >= 27 && e < 72), 1'b0}) begin
            errors++;
            $display("FAIL long_norepeat edge %0d got pr=%b lg=%b exp pr=%b lg=%b", e, pr1, lg1,
                     {(e == 7), 1'b0}, {(e >= 27 && e < 72), 1'b0});
         end
      end
      idle(5);
   endtask

   task automatic test_simultaneous;
      for (int e = 1; e <= 32; e++) begin
         step((e <= 20) ? 2'b00 : 2'b11, 1'b0);
         checks++;
         if (pr0 !== ((e == 7) ? 2'b11 : 2'b00) || rl0 !== ((e == 27) ? 2'b11 : 2'b00) ||
             lv0 !== ((e >= 7 && e < 27) ? 2'b11 : 2'b00)) begin
            errors++;
            $display("FAIL simultaneous edge %0d got pr=%b rl=%b lv=%b", e, pr0, rl0, lv0);
         end
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({o_lv[d], o_pr[d], o_rl[d], o_lg[d]} !== {m_lv[d], m_pr[d], m_rl[d], m_lg[d]}) begin
               errors++;
               $display("FAIL model_simul inst%0d edge %0d got %b%b%b%b exp %b%b%b%b", d, e,
                        o_lv[d], o_pr[d], o_rl[d], o_lg[d], m_lv[d], m_pr[d], m_rl[d], m_lg[d]);
            end
         end
      end
      idle(5);
   endtask

   task automatic test_reset_mid_hold;
      repeat (35) step(2'b10, 1'b0);
      checks++;
      if (lg0 !== 2'b01 || lv0 !== 2'b01) begin
         errors++; $display("FAIL pre_reset_hold got lg=%b lv=%b exp lg=01 lv=01", lg0, lv0);
      end
      step(2'b10, 1'b1);
      checks++;
      if ({lv0, pr0, rl0, lg0, lv1, pr1, rl1, lg1} !== 16'h0000) begin
         errors++; $display("FAIL reset_mid_hold got %h exp 0000", {lv0, pr0, rl0, lg0, lv1, pr1, rl1, lg1});
      end
      for (int e = 1; e <= 12; e++) begin
         step(2'b10, 1'b0);
         checks++;
         if (rl0 !== 2'b00 || pr0 !== ((e == 7) ? 2'b01 : 2'b00) || lv0 !== ((e >= 7) ? 2'b01 : 2'b00)) begin
            errors++;
            $display("FAIL after_reset edge %0d got pr=%b lv=%b rl=%b exp pr=%b lv=%b rl=00", e, pr0, lv0, rl0,
                     (e == 7) ? 2'b01 : 2'b00, (e >= 7) ? 2'b01 : 2'b00);
         end
      end
      idle(15);
   endtask

   task automatic test_release_bounce;
      for (int e = 1; e <= 45; e++) begin
         step((e <= 30 || e == 33) ? 2'b10 : 2'b11, 1'b0);
         checks++;
         if (pr0 !== ((e == 7 || e == 27) ? 2'b01 : 2'b00) || lg0 !== ((e >= 27 && e < 35) ? 2'b01 : 2'b00) ||
             lv0 !== ((e >= 7 && e < 40) ? 2'b01 : 2'b00) || rl0 !== ((e == 40) ? 2'b01 : 2'b00)) begin
            errors++;
            $display("FAIL release_bounce edge %0d got pr=%b lg=%b lv=%b rl=%b", e, pr0, lg0, lv0, rl0);
         end
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({o_lv[d], o_pr[d], o_rl[d], o_lg[d]} !== {m_lv[d], m_pr[d], m_rl[d], m_lg[d]}) begin
               errors++;
               $display("FAIL model_relbounce inst%0d edge %0d got %b%b%b%b exp %b%b%b%b", d, e,
                        o_lv[d], o_pr[d], o_rl[d], o_lg[d], m_lv[d], m_pr[d], m_rl[d], m_lg[d]);
            end
         end
      end
      idle(5);
   endtask

   task automatic test_random;
      logic [1:0] k;
      int         left[2];
      logic       r;
      k = 2'b11;
      left[0] = 1; left[1] = 1;
      repeat (2000) begin
         for (int c = 0; c < 2; c++) begin
            left[c] = left[c] - 1;
            if (left[c] <= 0) begin
               k[c] = ~k[c];
               left[c] = (k[c] == 1'b0) ? $urandom_range(60, 1) : $urandom_range(20, 1);
            end
         end
         r = ($urandom_range(399, 0) == 0);
         step(k, r);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({o_lv[d], o_pr[d], o_rl[d], o_lg[d]} !== {m_lv[d], m_pr[d], m_rl[d], m_lg[d]}) begin
               errors++;
               $display("FAIL model_random inst%0d key=%b got %b%b%b%b exp %b%b%b%b", d, k,
                        o_lv[d], o_pr[d], o_rl[d], o_lg[d], m_lv[d], m_pr[d], m_rl[d], m_lg[d]);
            end
         end
      end
   endtask

   initial begin
      key = 2'b11;
      rst = 1'b1;
      test_reset;
      test_clean_press;
      test_bounce;
      test_long_hold;
      test_simultaneous;
      test_reset_mid_hold;
      test_release_bounce;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
